// File: rtl/led_pulse_driver_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_pulse_driver_pkg: shared FSM encodings and block defaults              |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package led_pulse_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } led_state_e;

  localparam int C_DEF_WIDTH          = 1;
  localparam int C_DEF_TICK_COUNT_MAX = 25000;
  localparam int C_DEF_ON_TICKS       = 150;
  localparam int C_DEF_OFF_TICKS      = 150;
  localparam int C_DEF_PENDING_MAX    = 3;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage : led_pulse_driver_pkg
`default_nettype wire

// File: rtl/led_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_channel: one blink-stretching FSM with a saturating pending counter    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module led_channel
  import led_pulse_driver_pkg::*;
#(
  parameter int ON_TICKS    = C_DEF_ON_TICKS,
  parameter int OFF_TICKS   = C_DEF_OFF_TICKS,
  parameter int PENDING_MAX = C_DEF_PENDING_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic pulse,
  output logic led
);

  localparam int C_TICK_W = cnt_width(((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS) - 1);
  localparam int C_PEND_W = cnt_width(PENDING_MAX);

  localparam logic [C_TICK_W-1:0] C_ON_LAST  = C_TICK_W'(ON_TICKS - 1);
  localparam logic [C_TICK_W-1:0] C_OFF_LAST = C_TICK_W'(OFF_TICKS - 1);
  localparam logic [C_PEND_W-1:0] C_PEND_MAX = C_PEND_W'(PENDING_MAX);

  led_state_e          state_q, state_d;
  logic [C_TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [C_PEND_W-1:0] pending_q, pending_d;
  logic                led_q, led_d;
  logic                w_pend_sat;

  assign w_pend_sat = (pending_q == C_PEND_MAX);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    pending_d  = pending_q;

    case (state_q)
      ST_IDLE: begin
        if (pulse) begin
          state_d    = ST_ON;
          tick_cnt_d = '0;
        end
      end

      ST_ON: begin
        if (tick) begin
          if (tick_cnt_q == C_ON_LAST) begin
            state_d    = ST_OFF;
            tick_cnt_d = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        if (pulse && !w_pend_sat) begin
          pending_d = pending_q + 1'b1;
        end
      end

      ST_OFF: begin
        if (tick && (tick_cnt_q == C_OFF_LAST)) begin
          tick_cnt_d = '0;
          // A same-cycle pulse replaces the queued pulse being consumed.
          if (pending_q != '0) begin
            state_d = ST_ON;
            if (!pulse) begin
              pending_d = pending_q - 1'b1;
            end
          end else if (pulse) begin
            state_d = ST_ON;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (tick) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
          if (pulse && !w_pend_sat) begin
            pending_d = pending_q + 1'b1;
          end
        end
      end

      default: begin
        state_d    = ST_IDLE;
        tick_cnt_d = '0;
        pending_d  = '0;
      end
    endcase

    led_d = (state_d == ST_ON);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      pending_q  <= '0;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      pending_q  <= pending_d;
      led_q      <= led_d;
    end
  end

  assign led = led_q;

endmodule : led_channel
`default_nettype wire

// File: rtl/led_pulse_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_pulse_driver: shared tick prescaler feeding WIDTH blink channels       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module led_pulse_driver
  import led_pulse_driver_pkg::*;
#(
  parameter int WIDTH          = C_DEF_WIDTH,
  parameter int TICK_COUNT_MAX = C_DEF_TICK_COUNT_MAX,
  parameter int ON_TICKS       = C_DEF_ON_TICKS,
  parameter int OFF_TICKS      = C_DEF_OFF_TICKS,
  parameter int PENDING_MAX    = C_DEF_PENDING_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pulse_in,
  output logic [WIDTH-1:0] led_out
);

  localparam int                 C_PRE_W    = cnt_width(TICK_COUNT_MAX - 1);
  localparam logic [C_PRE_W-1:0] C_PRE_LAST = C_PRE_W'(TICK_COUNT_MAX - 1);

  logic [C_PRE_W-1:0] presc_q, presc_d;
  logic               w_tick;

  assign w_tick = (presc_q == C_PRE_LAST);

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (w_tick) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    led_channel #(
      .ON_TICKS   (ON_TICKS),
      .OFF_TICKS  (OFF_TICKS),
      .PENDING_MAX(PENDING_MAX)
    ) u_led_channel (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick),
      .pulse(pulse_in[gi]),
      .led  (led_out[gi])
    );
  end : g_ch

endmodule : led_pulse_driver
`default_nettype wire

// File: tb/tb_led_pulse_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_led_pulse_driver: directed and random checks against a timeline model   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_led_pulse_driver;

  localparam int W    = 2;
  localparam int T    = 4;
  localparam int ONT  = 2;
  localparam int OFFT = 1;
  localparam int PMAX = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] pulse_in = '0;
  logic [W-1:0] led_out;

  led_pulse_driver #(
    .WIDTH         (W),
    .TICK_COUNT_MAX(T),
    .ON_TICKS      (ONT),
    .OFF_TICKS     (OFFT),
    .PENDING_MAX   (PMAX)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pulse_in(pulse_in),
    .led_out (led_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  string tag = "reset";

  // Timeline model: edge n counts clock edges since reset released; a tick
  // falls on every edge with n % T == T-1. Each blink is an interval of edges.
  int           n;
  bit           busy   [W];
  int           k_on   [W];
  int           m_off  [W];
  int           e_exit [W];
  int           pend   [W];
  logic [W-1:0] exp_led;

  int   rises0;
  logic prev0;

  function automatic int first_tick(input int from);
    return from + ((T - 1 - (from % T) + T) % T);
  endfunction

  task automatic start_blink(input int ch, input int at);
    busy[ch]   = 1'b1;
    k_on[ch]   = at;
    m_off[ch]  = first_tick(at + 1) + (ONT - 1) * T;
    e_exit[ch] = first_tick(m_off[ch] + 1) + (OFFT - 1) * T;
  endtask

  task automatic model_edge(input logic [W-1:0] p, input logic r);
    if (r) begin
      n = 0;
      for (int c = 0; c < W; c++) begin
        busy[c] = 1'b0;
        pend[c] = 0;
      end
      exp_led = '0;
    end else begin
      for (int c = 0; c < W; c++) begin
        if (!busy[c]) begin
          if (p[c]) start_blink(c, n);
        end else if (n == e_exit[c]) begin
          if (pend[c] > 0 || p[c]) begin
            pend[c] = (pend[c] > 0) ? pend[c] - 1 + int'(p[c]) : 0;
            start_blink(c, n);
          end else begin
            busy[c] = 1'b0;
          end
        end else if (p[c]) begin
          pend[c] = (pend[c] < PMAX) ? pend[c] + 1 : PMAX;
        end
        exp_led[c] = busy[c] && (n >= k_on[c]) && (n < m_off[c]);
      end
      n++;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic [W-1:0] p, input logic r);
    pulse_in = p;
    rst      = r;
    @(posedge clk);
    model_edge(p, r);
    #1;
    total++;
    assert (led_out === exp_led)
    else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, n, led_out, exp_led);
    end
    if (led_out[0] === 1'b1 && prev0 === 1'b0) rises0++;
    prev0 = led_out[0];
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step('0, 1'b0);
  endtask

  task automatic check_int(input string name, input int obs, input int expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, expv);
    end
  endtask

  initial begin
    n       = 0;
    exp_led = '0;
    rises0  = 0;
    prev0   = 1'b0;
    for (int c = 0; c < W; c++) begin
      busy[c] = 1'b0;
      pend[c] = 0;
    end
    @(negedge clk);

    // Reset, with pulses present that must be ignored.
    tag = "reset";
    step('0, 1'b1);
    step(2'b11, 1'b1);
    step('0, 1'b1);

    // Single pulse on ch0.
    tag = "single"; rises0 = 0;
    step(2'b01, 1'b0);
    idle(20);
    check_int("single_blinks", rises0, 1);

    // Three pulses inside one on-period, third dropped at saturation.
    tag = "sat"; rises0 = 0;
    step(2'b01, 1'b0);
    step(2'b01, 1'b0);
    step(2'b01, 1'b0);
    step(2'b01, 1'b0);
    idle(45);
    check_int("sat_blinks", rises0, 3);

    // Pulse landing exactly on the off-exit edge with nothing pending.
    tag = "exit_pulse"; rises0 = 0;
    step(2'b01, 1'b0);
    while (n < e_exit[0]) step('0, 1'b0);
    step(2'b01, 1'b0);
    check_int("exit_pulse_led", int'(led_out[0]), 1);
    idle(30);
    check_int("exit_pulse_blinks", rises0, 2);

    // Simultaneous pulses on both channels.
    tag = "dual";
    step(2'b11, 1'b0);
    check_int("dual_rise", int'(led_out), 3);
    idle(20);

    // Reset mid-on with two queued pulses.
    tag = "rst_mid"; rises0 = 0;
    step(2'b01, 1'b0);
    step(2'b01, 1'b0);
    step(2'b01, 1'b0);
    step('0, 1'b1);
    check_int("rst_mid_led", int'(led_out), 0);
    idle(30);
    check_int("rst_mid_blinks", rises0, 1);
    rises0 = 0;
    step(2'b01, 1'b0);
    idle(20);
    check_int("post_rst_blinks", rises0, 1);

    // Continuous pulse stream on ch0.
    tag = "stream";
    for (int i = 0; i < 40; i++) step(2'b01, 1'b0);
    idle(50);

    // Random pulses with occasional resets.
    tag = "random";
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] p;
      logic         r;
      p[0] = ($urandom_range(0, 5) == 0);
      p[1] = ($urandom_range(0, 5) == 0);
      r    = ($urandom_range(0, 99) == 0);
      step(p, r);
    end
    idle(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_led_pulse_driver
`default_nettype wire
